// File: rtl/tagged_norm_fifo_reader.sv
// Consumer side of the TaggedNormalized FIFO: credit-limited read pulses feed a small local buffer
// drained over valid/ready. Define TAG_ORDER_CHECK_EN to enable the tag sequence checker.
`ifndef TAG_SIZE
`define TAG_SIZE 8
`endif

package tagged_norm_pkg;
  typedef struct packed {
    logic [`TAG_SIZE-1:0] tag;
    logic [47:0]          normal;
  } tagged_normalized_t;
endpackage

module tagged_norm_fifo_reader
  import tagged_norm_pkg::*;
#(
  parameter int SKID_DEPTH = 2,
  parameter int TAG_SIZE   = `TAG_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  drain_en,
  input  logic                  fifo_ready,
  output logic                  fifo_read,
  input  logic                  fifo_valid,
  input  tagged_normalized_t    fifo_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output tagged_normalized_t    out_data,
  output logic [TAG_SIZE-1:0]   out_tag,
  output logic [7:0]            miss_count,
  output logic [15:0]           rx_count,
  output logic                  drop_err,
  output logic                  tag_error
);
  localparam int OW = $clog2(SKID_DEPTH + 1);
  localparam int PW = $clog2(SKID_DEPTH);
  localparam logic [OW-1:0] DEPTH_OCC  = OW'(SKID_DEPTH);
  localparam logic [OW:0]   DEPTH_CRED = (OW + 1)'(SKID_DEPTH);

  tagged_normalized_t mem_q [SKID_DEPTH];

  logic [OW-1:0] occ_q, occ_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic          inflight_q;
  logic [7:0]    miss_count_q, miss_count_d;
  logic [15:0]   rx_count_q, rx_count_d;
  logic          drop_err_q, drop_err_d;
  logic          pop, capture;
  logic [OW:0]   credit_used;

  // Outstanding credit counts a read still awaiting its response window.
  assign credit_used = {1'b0, occ_q} + {{OW{1'b0}}, inflight_q};
  assign fifo_read   = drain_en & fifo_ready & ~reset & (credit_used < DEPTH_CRED);

  always_comb begin
    pop          = (occ_q != '0) && out_ready;
    capture      = fifo_valid && ((occ_q < DEPTH_OCC) || pop);
    occ_d        = occ_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    miss_count_d = miss_count_q;
    rx_count_d   = rx_count_q;
    drop_err_d   = drop_err_q;
    if (pop)
      rd_ptr_d = rd_ptr_q + PW'(1);
    if (capture) begin
      wr_ptr_d   = wr_ptr_q + PW'(1);
      rx_count_d = rx_count_q + 16'd1;
    end else if (fifo_valid) begin
      drop_err_d = 1'b1;
    end
    if (capture && !pop)
      occ_d = occ_q + OW'(1);
    else if (pop && !capture)
      occ_d = occ_q - OW'(1);
    if (inflight_q && !fifo_valid && (miss_count_q != 8'hFF))
      miss_count_d = miss_count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      inflight_q   <= 1'b0;
      miss_count_q <= '0;
      rx_count_q   <= '0;
      drop_err_q   <= 1'b0;
    end else begin
      occ_q        <= occ_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      inflight_q   <= fifo_read;
      miss_count_q <= miss_count_d;
      rx_count_q   <= rx_count_d;
      drop_err_q   <= drop_err_d;
    end
  end

  // Buffer contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (capture)
      mem_q[wr_ptr_q] <= fifo_data;
  end

  assign out_valid  = (occ_q != '0);
  assign out_data   = mem_q[rd_ptr_q];
  assign out_tag    = out_data.tag;
  assign miss_count = miss_count_q;
  assign rx_count   = rx_count_q;
  assign drop_err   = drop_err_q;

`ifdef TAG_ORDER_CHECK_EN
  logic [TAG_SIZE-1:0] expected_tag_q, expected_tag_d;
  logic                tag_error_q, tag_error_d;

  // Every capture resyncs the expectation, so one gap yields one pulse.
  always_comb begin
    expected_tag_d = expected_tag_q;
    tag_error_d    = 1'b0;
    if (capture) begin
      tag_error_d    = (fifo_data.tag != expected_tag_q);
      expected_tag_d = fifo_data.tag + TAG_SIZE'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      expected_tag_q <= '0;
      tag_error_q    <= 1'b0;
    end else begin
      expected_tag_q <= expected_tag_d;
      tag_error_q    <= tag_error_d;
    end
  end

  assign tag_error = tag_error_q;
`else
  assign tag_error = 1'b0;
`endif

endmodule

// File: tb/tb_tagged_norm_fifo_reader.sv
// Self-checking bench for tagged_norm_fifo_reader: directed table, hand sequences and a random run
// against a queue-based reference model of the reader and a simple FIFO responder.
`ifndef TAG_SIZE
`define TAG_SIZE 8
`endif

module tb_tagged_norm_fifo_reader;
  import tagged_norm_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset, drain_en, fifo_ready, fifo_read, fifo_valid;
  logic out_valid, out_ready, drop_err, tag_error;
  tagged_normalized_t fifo_data, out_data;
  logic [`TAG_SIZE-1:0] out_tag;
  logic [7:0]  miss_count;
  logic [15:0] rx_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tagged_norm_fifo_reader #(.SKID_DEPTH(DEPTH), .TAG_SIZE(`TAG_SIZE)) dut (
    .clk(clk), .reset(reset), .drain_en(drain_en), .fifo_ready(fifo_ready),
    .fifo_read(fifo_read), .fifo_valid(fifo_valid), .fifo_data(fifo_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .miss_count(miss_count), .rx_count(rx_count), .drop_err(drop_err), .tag_error(tag_error)
  );

  // FIFO responder: items waiting in the FIFO and the response owed next cycle.
  tagged_normalized_t src[$];
  bit                 resp_pending;
  tagged_normalized_t resp_item;
  bit                 ignore_next;
  bit                 spurious_valid;
  tagged_normalized_t spurious_item;

  // Reference model: buffer contents as a queue plus plain counters.
  tagged_normalized_t mq[$];
  bit                 m_inflight;
  int                 m_miss, m_rx;
  bit                 m_drop, m_tag_err;
  logic [`TAG_SIZE-1:0] m_exp_tag;
  bit                 exp_read;
  int                 n_reads, n_pops, n_tagerr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic tagged_normalized_t mk(input int tag);
    tagged_normalized_t it;
    it.tag    = `TAG_SIZE'(tag);
    it.normal = 48'({$urandom(), $urandom()});
    return it;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_inflight   = 1'b0;
    m_miss       = 0;
    m_rx         = 0;
    m_drop       = 1'b0;
    m_tag_err    = 1'b0;
    m_exp_tag    = '0;
    resp_pending = 1'b0;
    ignore_next  = 1'b0;
    spurious_valid = 1'b0;
  endfunction

  // Drive one cycle's inputs at the falling edge and check all outputs against the model.
  task automatic cycle_begin(input bit drain, input bit oready);
    @(negedge clk);
    drain_en   = drain;
    out_ready  = oready;
    fifo_ready = (src.size() != 0);
    fifo_valid = resp_pending || spurious_valid;
    fifo_data  = resp_pending ? resp_item : spurious_item;
    #1;
    exp_read = drain && (src.size() != 0) && ((mq.size() + int'(m_inflight)) < DEPTH);
    chk("fifo_read", 64'(fifo_read), 64'(exp_read));
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_data", 64'(out_data), 64'(mq[0]));
      chk("out_tag", 64'(out_tag), 64'(mq[0].tag));
    end
    chk("miss_count", 64'(miss_count), 64'(m_miss));
    chk("rx_count", 64'(rx_count), 64'(m_rx));
    chk("drop_err", 64'(drop_err), 64'(m_drop));
    chk("tag_error", 64'(tag_error), 64'(m_tag_err));
    n_reads  += int'(fifo_read);
    n_pops   += int'(out_valid && out_ready);
    n_tagerr += int'(tag_error);
  endtask

  // Advance the model across the coming rising edge.
  task automatic cycle_end();
    bit pop, cap;
    pop = (mq.size() != 0) && out_ready;
    cap = fifo_valid && ((mq.size() < DEPTH) || pop);
    m_tag_err = 1'b0;
    if (pop) void'(mq.pop_front());
    if (cap) begin
`ifdef TAG_ORDER_CHECK_EN
      m_tag_err = (fifo_data.tag != m_exp_tag);
      m_exp_tag = `TAG_SIZE'(fifo_data.tag + 1);
`endif
      mq.push_back(fifo_data);
      m_rx = (m_rx + 1) % 65536;
    end else if (fifo_valid) begin
      m_drop = 1'b1;
    end
    if (m_inflight && !fifo_valid) m_miss = (m_miss < 255) ? m_miss + 1 : 255;
    m_inflight     = exp_read;
    spurious_valid = 1'b0;
    resp_pending   = 1'b0;
    if (exp_read) begin
      if (ignore_next) ignore_next = 1'b0;
      else begin
        resp_pending = 1'b1;
        resp_item    = src.pop_front();
      end
    end
  endtask

  task automatic run(input int n, input bit drain, input bit oready);
    for (int i = 0; i < n; i++) begin
      cycle_begin(drain, oready);
      cycle_end();
    end
  endtask

  task automatic idle_inputs();
    fifo_valid = 1'b0;
    drain_en   = 1'b0;
    fifo_ready = 1'b0;
    out_ready  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_fifo_read", 64'(fifo_read), 64'(0));
    model_reset();
    src.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit drain;
    bit oready;
    bit e_read;
    bit e_valid;
    int e_tag;
  } vec_t;

  vec_t t1[7];
  tagged_normalized_t head, late;
  int rx_before, next_tag;

  initial begin
    t1 = '{'{1, 1, 1, 0, 0}, '{1, 1, 1, 0, 0}, '{1, 1, 0, 1, 0}, '{1, 1, 1, 1, 1},
           '{1, 1, 0, 0, 0}, '{1, 1, 0, 1, 2}, '{1, 1, 0, 0, 0}};
    reset = 1'b1;
    idle_inputs();
    fifo_data     = '0;
    spurious_item = '0;
    resp_item     = '0;
    model_reset();
    n_reads = 0; n_pops = 0; n_tagerr = 0;

    // Reset state with read conditions otherwise true.
    @(negedge clk);
    drain_en = 1'b1;
    fifo_ready = 1'b1;
    #1;
    chk("reset_fifo_read", 64'(fifo_read), 64'(0));
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_counts", 64'({miss_count, rx_count, drop_err, tag_error}), 64'(0));
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;

    // Tags 0,1,2 streamed with downstream always ready.
    $display("[TB] stream three items");
    for (int i = 0; i < 3; i++) src.push_back(mk(i));
    foreach (t1[i]) begin
      cycle_begin(t1[i].drain, t1[i].oready);
      chk("t1_read", 64'(fifo_read), 64'(t1[i].e_read));
      chk("t1_valid", 64'(out_valid), 64'(t1[i].e_valid));
      if (t1[i].e_valid) chk("t1_tag", 64'(out_tag), 64'(t1[i].e_tag));
      cycle_end();
    end
    cycle_begin(1, 1);
    chk("t1_rx", 64'(rx_count), 64'(3));
    chk("t1_miss", 64'(miss_count), 64'(0));
    cycle_end();

    // Downstream stalled: only two reads fit, then drain the rest.
    $display("[TB] stalled downstream, five items");
    for (int i = 3; i < 8; i++) src.push_back(mk(i));
    n_reads = 0;
    run(8, 1, 0);
    chk("t2_reads", 64'(n_reads), 64'(2));
    n_pops = 0;
    run(14, 1, 1);
    chk("t2_pops", 64'(n_pops), 64'(5));
    chk("t2_drop", 64'(drop_err), 64'(0));

    // One read ignored by the FIFO.
    $display("[TB] ignored read");
    for (int i = 8; i < 11; i++) src.push_back(mk(i));
    ignore_next = 1'b1;
    run(10, 1, 1);
    cycle_begin(1, 1);
    chk("t3_miss", 64'(miss_count), 64'(1));
    chk("t3_rx", 64'(rx_count), 64'(11));
    cycle_end();

    // Spurious valid into a full buffer.
    $display("[TB] spurious valid into full buffer");
    src.push_back(mk(11));
    src.push_back(mk(12));
    run(4, 1, 0);
    head = mq[0];
    rx_before = m_rx;
    spurious_valid = 1'b1;
    spurious_item  = mk(99);
    run(1, 0, 0);
    cycle_begin(0, 0);
    chk("t4_drop", 64'(drop_err), 64'(1));
    chk("t4_rx", 64'(rx_count), 64'(rx_before));
    chk("t4_head", 64'(out_data), 64'(head));
    cycle_end();
    run(3, 0, 0);
    cycle_begin(0, 0);
    chk("t4_drop_sticky", 64'(drop_err), 64'(1));
    cycle_end();
    do_reset();

    // Tag gap 0,1,3,4.
    $display("[TB] tag sequence with gap");
    src.push_back(mk(0)); src.push_back(mk(1)); src.push_back(mk(3)); src.push_back(mk(4));
    n_tagerr = 0;
    run(12, 1, 1);
`ifdef TAG_ORDER_CHECK_EN
    chk("t5_tag_pulses", 64'(n_tagerr), 64'(1));
`else
    chk("t5_tag_pulses", 64'(n_tagerr), 64'(0));
`endif

    // Reset asserted while a read is in flight and one item is buffered.
    $display("[TB] reset mid-operation");
    src.push_back(mk(5));
    src.push_back(mk(6));
    run(2, 1, 0);
    late = resp_item;
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    #1;
    chk("t6_out_valid", 64'(out_valid), 64'(0));
    chk("t6_counts", 64'({miss_count, rx_count}), 64'(0));
    chk("t6_fifo_read", 64'(fifo_read), 64'(0));
    model_reset();
    src.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    spurious_valid = 1'b1;
    spurious_item  = late;
    run(1, 0, 0);
    cycle_begin(0, 0);
    chk("t6_late_rx", 64'(rx_count), 64'(1));
    cycle_end();
    do_reset();

    // Randomized traffic.
    $display("[TB] random traffic");
    next_tag = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0 && src.size() < 4) begin
        src.push_back(mk(next_tag));
        next_tag += ($urandom_range(0, 15) == 0) ? 2 : 1;
      end
      if ($urandom_range(0, 19) == 0) ignore_next = 1'b1;
      if (!resp_pending && $urandom_range(0, 29) == 0) begin
        spurious_valid = 1'b1;
        spurious_item  = mk(int'($urandom_range(0, 255)));
      end
      cycle_begin($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      cycle_end();
    end
    do_reset();

    // Miss counter saturation.
    $display("[TB] miss counter saturation");
    src.push_back(mk(0));
    for (int i = 0; i < 270; i++) begin
      ignore_next = 1'b1;
      cycle_begin(1, 1);
      cycle_end();
    end
    cycle_begin(0, 1);
    chk("t7_miss_sat", 64'(miss_count), 64'(255));
    cycle_end();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tagged_norm_fifo_reader.md
Name: tagged_norm_fifo_reader

Overview:
- Consumer side of the TaggedNormalized FIFO protocol.
- The FIFO exposes `ready` (non-empty), accepts a one-cycle `read` pulse, and returns data with `valid` on the following cycle.
- This block issues credit-limited read pulses, captures returned items into a small local buffer, and presents them downstream on a valid/ready handshake.
- Sits between the normalize-stage FIFO and the ray-dispatch consumer; also counts missed reads and tags received.

Parameters:
- SKID_DEPTH, 2: local buffer entries; power of two, ≥2.
- TAG_SIZE, `TAG_SIZE: width of the tag field of TaggedNormalized.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- drain_en  in  1  allow new FIFO reads; 0 stalls reads, local buffer still drains.
- fifo_ready  in  1  FIFO non-empty indication.
- fifo_read  out  1  read pulse to FIFO, combinational from registered state and inputs.
- fifo_valid  in  1  FIFO data valid, one cycle after an honoured read.
- fifo_data  in  TaggedNormalized  FIFO read data.
- out_valid  out  1  local buffer non-empty.
- out_ready  in  1  downstream accept.
- out_data  out  TaggedNormalized  head of local buffer.
- out_tag  out  TAG_SIZE  tag field of out_data.
- miss_count  out  8  reads not answered by fifo_valid; saturating.
- rx_count  out  16  items accepted into the buffer; wraps.
- drop_err  out  1  sticky: fifo_valid arrived with no space.
- tag_error  out  1  one-cycle pulse on tag sequence mismatch (see Optional Feature).

Behaviour:
- Reset (async): buffer pointers = 0, occupancy = 0, inflight = 0, miss_count = 0, rx_count = 0, drop_err = 0, tag_error = 0, expected_tag = 0.
  - Hence out_valid = 0 and fifo_read = 0 during reset. Buffer contents are not reset.
- State:
  - occ: buffer occupancy, width $clog2(SKID_DEPTH+1).
  - inflight: 1 bit; a read was issued last cycle.
  - rd_ptr, wr_ptr: $clog2(SKID_DEPTH) bits, wrap modulo SKID_DEPTH.
- Read issue: fifo_read = drain_en & fifo_ready & ~reset & (occ + inflight < SKID_DEPTH).
  - Uses registered occ only; a same-cycle downstream pop does not grant credit until the next cycle.
  - At most one read per cycle.
  - Back-to-back reads are allowed when credit permits: 2 outstanding slots are never exceeded because inflight is counted.
- inflight <= fifo_read each cycle.
  - The response window is exactly the next cycle, and inflight is cleared after it whether or not data came.
- Miss: inflight=1 and fifo_valid=0 → miss_count increments, saturating at 255. The credit is implicitly returned.
  - Covers the FIFO ignoring a read, e.g. full with a simultaneous write.
- Capture: fifo_valid=1 and (occ<SKID_DEPTH, or a pop in the same cycle) → write buf[wr_ptr], wr_ptr++, rx_count++.
  - Applies regardless of inflight, so a spurious valid is accepted if space exists.
- Drop: fifo_valid=1 with occ==SKID_DEPTH and no same-cycle pop → data discarded, drop_err <= 1 (sticky until reset).
- Pop: out_valid & out_ready → rd_ptr++.
- occ update: +1 on capture, −1 on pop; simultaneous capture and pop leaves occ unchanged.
- Output path: out_valid = (occ != 0); out_data = buf[rd_ptr]; out_tag = buf[rd_ptr].tag.
  - All three are combinational from registers.
  - out_data is held stable while out_valid & ~out_ready.
- drain_en low: no new reads. An already-inflight response is still captured. Downstream pops continue.
- Reset mid-operation: all state cleared immediately. A FIFO response arriving after reset release is handled as a spurious valid per the Capture/Drop rules.

Optional Feature:
- Macro: TAG_ORDER_CHECK_EN.
- Defined:
  - On each capture, compare fifo_data.tag with expected_tag.
  - On mismatch, tag_error pulses high for one cycle, registered and coincident with the cycle after capture.
  - expected_tag <= fifo_data.tag + 1, modulo 2^TAG_SIZE, on every capture; this resyncs after an error.
  - Dropped items do not update expected_tag.
- Undefined: tag_error tied 0; no expected_tag register.

Test Plan:
- FIFO holds tags 0,1,2, out_ready=1, drain_en=1 → reads on consecutive cycles as credit allows; out_tag sequence 0,1,2; rx_count=3; miss_count=0; tag_error never 1.
- out_ready=0, FIFO holds 5 items → exactly 2 reads issued, then fifo_read stays 0; occ=2; raise out_ready → remaining 3 drained; no drop_err.
- FIFO model ignores one read (no fifo_valid next cycle) → miss_count=1; credit restored; next read issues on the following eligible cycle.
- Inject fifo_valid with no read while occ=2, out_ready=0 → drop_err=1 and stays 1; rx_count unchanged; out_data unchanged.
- With TAG_ORDER_CHECK_EN, feed tags 0,1,3,4 → tag_error pulses once, after tag 3; no further pulse on tag 4.
- Assert reset with inflight=1 and occ=1 → out_valid=0, counters 0; late fifo_valid after release is captured; rx_count=1.
